// File: rtl/line_fill_buffer.sv
// line_fill_buffer
//
// Builds one cache line from a multi-beat memory read burst. The line is then
// presented to the downstream word-select mux together with a registered word
// offset. Only one fill is in flight at a time.
//
// Ports:
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_fill_req       start a fill (only looked at while idle)
//   i_fill_addr      byte address: [31:5] line, [4:2] word offset, [1:0] unused
//   o_pmem_read      burst read request, high for the whole burst
//   o_pmem_address   line-aligned burst address
//   i_pmem_resp      one beat valid on i_pmem_rdata this cycle
//   i_pmem_rdata     beat data, lowest line address first
//   o_busy           fill in progress
//   o_fill_done      one-cycle pulse when the line is complete
//   o_line_valid     o_line_out holds a complete line
//   o_line_out       assembled line, word i = o_line_out[32*i +: 32]
//   o_word_sel       latched word offset for the downstream mux select
module line_fill_buffer #(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned NUM_BEATS  = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_fill_req,
  input  logic [31:0]                       i_fill_addr,
  output logic                              o_pmem_read,
  output logic [31:0]                       o_pmem_address,
  input  logic                              i_pmem_resp,
  input  logic [BEAT_WIDTH-1:0]             i_pmem_rdata,
  output logic                              o_busy,
  output logic                              o_fill_done,
  output logic                              o_line_valid,
  output logic [NUM_BEATS*BEAT_WIDTH-1:0]   o_line_out,
  output logic [2:0]                        o_word_sel
);

  localparam int unsigned CntW  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned LineW = NUM_BEATS * BEAT_WIDTH;
  localparam logic [CntW-1:0] LastBeat = CntW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [31:0]       r_addr;
  logic [31:0]       w_addr_d;
  logic [2:0]        r_word_sel;
  logic [2:0]        w_word_sel_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [LineW-1:0]  r_line;
  logic [LineW-1:0]  w_line_d;
  logic              r_line_valid;
  logic              w_line_valid_d;

  logic              w_beat_we;
  logic              w_last_beat;

  assign w_beat_we   = (r_state == StFill) && i_pmem_resp;
  assign w_last_beat = (r_cnt == LastBeat);

  always_comb begin
    w_state_d      = r_state;
    w_addr_d       = r_addr;
    w_word_sel_d   = r_word_sel;
    w_cnt_d        = r_cnt;
    w_line_d       = r_line;
    w_line_valid_d = r_line_valid;

    // Beat write: only the slot addressed by the counter changes, so beats not
    // yet received keep whatever the previous line left there.
    for (int unsigned b = 0; b < NUM_BEATS; b++) begin
      if (w_beat_we && (r_cnt == CntW'(b))) begin
        w_line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = i_pmem_rdata;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (i_fill_req) begin
          w_addr_d       = {i_fill_addr[31:5], 5'b0};
          w_word_sel_d   = i_fill_addr[4:2];
          w_cnt_d        = '0;
          w_line_valid_d = 1'b0;
          w_state_d      = StFill;
        end
      end

      StFill: begin
        if (i_pmem_resp) begin
          if (w_last_beat) begin
            // Leave the counter parked; it is cleared on the next fill anyway.
            w_line_valid_d = 1'b1;
            w_state_d      = StDone;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_word_sel   <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_line_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_word_sel   <= w_word_sel_d;
      r_cnt        <= w_cnt_d;
      r_line       <= w_line_d;
      r_line_valid <= w_line_valid_d;
    end
  end

  // Control outputs decode straight from the state register, so nothing
  // combinational reaches them from the inputs.
  assign o_pmem_read    = (r_state == StFill);
  assign o_busy         = (r_state == StFill);
  assign o_fill_done    = (r_state == StDone);
  assign o_pmem_address = r_addr;
  assign o_line_valid   = r_line_valid;
  assign o_line_out     = r_line;
  assign o_word_sel     = r_word_sel;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Testbench for line_fill_buffer: directed fills from the test plan followed by
// randomized fills, stalls, ignored inputs and mid-burst resets. A scoreboard
// queue holds the expected completed line for each accepted fill; a monitor
// pops and compares on every fill_done pulse.
module tb_line_fill_buffer;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         fill_req;
  logic [31:0]  fill_addr;
  logic         pmem_resp;
  logic [63:0]  pmem_rdata;
  logic         o_pmem_read;
  logic [31:0]  o_pmem_address;
  logic         o_busy;
  logic         o_fill_done;
  logic         o_line_valid;
  logic [255:0] o_line_out;
  logic [2:0]   o_word_sel;

  line_fill_buffer #(
    .BEAT_WIDTH(64),
    .NUM_BEATS (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fill_req    (fill_req),
    .i_fill_addr   (fill_addr),
    .o_pmem_read   (o_pmem_read),
    .o_pmem_address(o_pmem_address),
    .i_pmem_resp   (pmem_resp),
    .i_pmem_rdata  (pmem_rdata),
    .o_busy        (o_busy),
    .o_fill_done   (o_fill_done),
    .o_line_valid  (o_line_valid),
    .o_line_out    (o_line_out),
    .o_word_sel    (o_word_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [255:0] line;
    logic [2:0]   ws;
    logic [31:0]  addr;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];

  // Reference view of what the buffer should be holding.
  logic [31:0]  m_addr;
  logic [255:0] m_line;
  logic [2:0]   m_ws;
  logic         m_lv;

  logic [63:0]  b_beats [NB];
  int           b_stalls[NB];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] line, input logic [2:0] idx);
    logic [255:0] sh;
    sh = line >> (32 * int'(idx));
    return sh[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: address stability during the burst and scoreboard compare on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (o_pmem_read) check("pmem_address_stable", o_pmem_address, m_addr);
        if (o_fill_done) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_fill_done: got pulse expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("done_line", o_line_out, e.line);
            check("done_word_sel", o_word_sel, e.ws);
            check("done_address", o_pmem_address, e.addr);
            check("done_cycle", cyc, e.done_cyc);
            check("done_line_valid", o_line_valid, 1'b1);
            check("done_busy", o_busy, 1'b0);
            check("done_pmem_read", o_pmem_read, 1'b0);
            check("done_selected_word", o_line_out[32*o_word_sel +: 32], word_of(e.line, e.ws));
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_pmem_read"}, o_pmem_read, 1'b0);
    check({tag, "_pmem_address"}, o_pmem_address, 32'h0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_fill_done"}, o_fill_done, 1'b0);
    check({tag, "_line_valid"}, o_line_valid, 1'b0);
    check({tag, "_line_out"}, o_line_out, 256'h0);
    check({tag, "_word_sel"}, o_word_sel, 3'h0);
    m_addr = '0;
    m_line = '0;
    m_ws   = '0;
    m_lv   = 1'b0;
  endtask

  // Idle cycles with random pmem_resp pulses; the held line must not move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      fill_req   = 1'b0;
      fill_addr  = $urandom;
      pmem_resp  = 1'($urandom_range(0, 1));
      pmem_rdata = {$urandom, $urandom};
      step();
      check("idle_line_hold", o_line_out, m_line);
      check("idle_word_sel_hold", o_word_sel, m_ws);
      check("idle_line_valid", o_line_valid, m_lv);
      check("idle_pmem_read", o_pmem_read, 1'b0);
    end
    pmem_resp = 1'b0;
  endtask

  // One fill using b_beats/b_stalls. abort_after < NB resets the DUT after
  // that many beats have been delivered.
  task automatic do_fill(input logic [31:0] addr, input int abort_after);
    exp_t e;
    int   s;
    s = 0;
    for (int i = 0; i < NB; i++) s += b_stalls[i];
    e.line = '0;
    for (int i = 0; i < NB; i++) e.line[64*i +: 64] = b_beats[i];
    e.ws       = addr[4:2];
    e.addr     = {addr[31:5], 5'b0};
    e.done_cyc = cyc + 5 + s;
    if (abort_after >= NB) sb.push_back(e);

    fill_req   = 1'b1;
    fill_addr  = addr;
    pmem_resp  = 1'($urandom_range(0, 1));
    pmem_rdata = {$urandom, $urandom};
    step();
    m_addr = e.addr;
    m_ws   = e.ws;
    m_lv   = 1'b0;
    check("fill_line_valid_cleared", o_line_valid, 1'b0);
    check("fill_word_sel_latched", o_word_sel, e.ws);
    check("fill_busy", o_busy, 1'b1);

    for (int b = 0; b < NB; b++) begin
      if (b == abort_after) begin
        rst        = 1'b1;
        fill_req   = 1'($urandom_range(0, 1));
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom};
        step();
        rst       = 1'b0;
        fill_req  = 1'b0;
        pmem_resp = 1'b0;
        check_reset_state("abort");
        sb.delete();
        return;
      end
      for (int k = 0; k < b_stalls[b]; k++) begin
        fill_req   = 1'($urandom_range(0, 1));
        fill_addr  = $urandom;
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom};
        step();
      end
      fill_req   = 1'($urandom_range(0, 1));
      fill_addr  = $urandom;
      pmem_resp  = 1'b1;
      pmem_rdata = b_beats[b];
      step();
    end
    // DONE cycle: everything on the inputs is ignored.
    fill_req   = 1'($urandom_range(0, 1));
    fill_addr  = $urandom;
    pmem_resp  = 1'($urandom_range(0, 1));
    pmem_rdata = {$urandom, $urandom};
    step();
    fill_req  = 1'b0;
    pmem_resp = 1'b0;
    m_line    = e.line;
    m_lv      = 1'b1;
  endtask

  task automatic check_pattern_line(input string tag);
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = 4'(i);
      check({tag, "_word"}, o_line_out[32*i +: 32], {8{nib}});
    end
    check({tag, "_sel_word"}, o_line_out[32*o_word_sel +: 32], 32'h5555_5555);
    check({tag, "_addr"}, o_pmem_address, 32'h0000_1220);
    check({tag, "_word_sel"}, o_word_sel, 3'd5);
  endtask

  task automatic set_pattern_beats();
    b_beats[0] = 64'h1111_1111_0000_0000;
    b_beats[1] = 64'h3333_3333_2222_2222;
    b_beats[2] = 64'h5555_5555_4444_4444;
    b_beats[3] = 64'h7777_7777_6666_6666;
  endtask

  task automatic set_random_beats(input int max_stall);
    for (int i = 0; i < NB; i++) begin
      b_beats[i]  = {$urandom, $urandom};
      b_stalls[i] = $urandom_range(0, max_stall);
    end
  endtask

  initial begin
    int waited;
    // Reset with random inputs, including fill_req, for two cycles.
    rst        = 1'b1;
    fill_req   = 1'b1;
    fill_addr  = $urandom;
    pmem_resp  = 1'b1;
    pmem_rdata = {$urandom, $urandom};
    step();
    fill_req   = 1'($urandom_range(0, 1));
    fill_addr  = $urandom;
    pmem_resp  = 1'($urandom_range(0, 1));
    pmem_rdata = {$urandom, $urandom};
    step();
    rst       = 1'b0;
    fill_req  = 1'b0;
    pmem_resp = 1'b0;
    check_reset_state("reset");
    idle(2);

    // Basic fill.
    set_pattern_beats();
    for (int i = 0; i < NB; i++) b_stalls[i] = 0;
    do_fill(32'h0000_1234, NB);
    check_pattern_line("basic");
    idle(3);

    // Stalls in cycles 2 and 4.
    b_stalls[1] = 1;
    b_stalls[2] = 1;
    do_fill(32'h0000_1234, NB);
    check_pattern_line("stall");
    idle(2);

    // Back-to-back: second request issued the first cycle back in idle.
    for (int i = 0; i < NB; i++) b_stalls[i] = 0;
    do_fill(32'h0000_1234, NB);
    set_random_beats(0);
    do_fill(32'h0000_2008, NB);
    check("b2b_word_sel", o_word_sel, 3'd2);
    check("b2b_addr", o_pmem_address, 32'h0000_2000);
    idle(1);

    // Reset after two beats, then a fresh fill.
    set_random_beats(1);
    do_fill($urandom, 2);
    idle(1);
    set_random_beats(1);
    do_fill($urandom, NB);

    // Random mix.
    for (int t = 0; t < 40; t++) begin
      set_random_beats(2);
      if ($urandom_range(0, 9) == 0) do_fill($urandom, $urandom_range(0, NB - 1));
      else do_fill($urandom, NB);
      idle($urandom_range(0, 2));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending fills expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_fill_buffer.md
# line_fill_buffer

Assembles a 256-bit cache line from a 4-beat, 64-bit physical-memory read burst and presents the completed line plus a registered 3-bit word offset. It sits directly upstream of the cache's 8:1 32-bit word-select mux: `line_out` slices feed the mux's eight data inputs and `word_sel` drives its select. One fill is handled at a time.

## Interface
- `BEAT_WIDTH`, 64, width of one memory beat; fixed: `4*BEAT_WIDTH` = 256.
- `NUM_BEATS`, 4, beats per line; beat counter is `$clog2(NUM_BEATS)` bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fill_req`  in  1  start a line fill; sampled only in IDLE.
- `fill_addr`  in  32  byte address of requested word; [31:5] line, [4:2] word offset, [1:0] ignored.
- `pmem_read`  out  1  burst read request to memory.
- `pmem_address`  out  32  line-aligned burst address.
- `pmem_resp`  in  1  one beat valid on `pmem_rdata` this cycle.
- `pmem_rdata`  in  64  beat data, lowest line address first.
- `busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse: line complete.
- `line_valid`  out  1  `line_out` holds a complete line.
- `line_out`  out  256  assembled line; word i = `line_out[32*i +: 32]`.
- `word_sel`  out  3  latched `fill_addr[4:2]`; drives the downstream mux select.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: `fill_req`=1 → latch `{fill_addr[31:5],5'b0}` into address register and `fill_addr[4:2]` into `word_sel`; clear beat counter; clear `line_valid`; go FILL. `pmem_resp` in IDLE ignored.
- FILL: `pmem_read`=1, `busy`=1, `pmem_address` = latched address (stable whole burst). Each cycle with `pmem_resp`=1: write `pmem_rdata` into `line_out[64*cnt +: 64]`, cnt+1. On beat with cnt = NUM_BEATS-1 → DONE. `pmem_resp`=0 cycles stall with no state change. `fill_req` ignored.
- DONE: `fill_done`=1, `line_valid`=1 (set on entry, held), `pmem_read`=0, `busy`=0; unconditionally → IDLE next cycle. `fill_req` ignored in DONE.
- `line_valid` stays 1 in IDLE until the next accepted `fill_req` or reset. `line_out` and `word_sel` hold their values between fills.
- During FILL `line_out` shows partially written data (unwritten beats keep old contents); consumers qualify with `line_valid`.
- Counter wraps cannot occur: transition to DONE precedes wrap; counter is cleared on each new fill.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE; `pmem_read`=0, `pmem_address`=0, `busy`=0, `fill_done`=0, `line_valid`=0, `line_out`=0, `word_sel`=0, counter 0.
- `rst` has priority over every other input in every state; reset mid-FILL aborts the burst, `pmem_read` low the following cycle, partial data discarded (`line_out` zeroed).
- `pmem_read`, `busy`, `fill_done` decode from the state register (no combinational path from inputs).
- Latency: `fill_req` sampled at edge 0 → `pmem_read` high in cycle 1. With `pmem_resp` high cycles 1–4, fourth beat captured at edge 5, `fill_done`/`line_valid` high in cycle 5, line visible on `line_out` in cycle 5. Minimum fill_req-to-done = 5 cycles; each stall cycle adds 1.
- Back-to-back: earliest next accepted `fill_req` is cycle 6 (IDLE).
- `word_sel` valid from cycle 1 of a fill; downstream word data valid when `line_valid`=1.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0 the cycle after; `fill_req` during reset ignored.
- Basic fill: `fill_addr`=0x0000_1234, beats 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, 0x5555_5555_4444_4444, 0x7777_7777_6666_6666 on consecutive cycles → `pmem_address`=0x0000_1220 through FILL, `word_sel`=5, `fill_done` single pulse in cycle 5, `line_out` word i = 0xiiii_iiii, selected word 0x5555_5555.
- Stalls: same fill with `pmem_resp` low in cycles 2 and 4 → done in cycle 7, identical line, `pmem_address` stable.
- Ignored inputs: `fill_req` with new address during FILL and DONE, `pmem_resp` pulses in IDLE → address/`word_sel`/`line_out` unchanged, no extra `fill_done`.
- Reset mid-burst: `rst` after 2 beats → IDLE next cycle, `pmem_read`=0, `line_valid`=0, `line_out`=0; a fresh fill then completes normally with 4 new beats.
- Back-to-back: second `fill_req` (addr 0x0000_2008) in cycle 6 → `line_valid` drops cycle 7, `word_sel`=2, second line replaces first, second `fill_done` in cycle 11.
